star_scanner: RTL and testbench

STAR_SCANNER -- requirements
Module: star_scanner

---
 rtl/star_scanner.sv | 194 +++++++++++++++++++
 tb/tb_star_scanner.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_scanner.sv
// Raster-scans an image ROM for bright pixels and hands each star seed to an external measurement stage.
// Optional STAR_MASK_EN: keep a table of measured extents and skip pixels inside already-recorded stars.
module star_scanner #(
    parameter logic [2:0]  THRESHOLD = 3'd0,
    parameter logic [5:0]  X_RES     = 6'd60,
    parameter logic [5:0]  Y_RES     = 6'd60,
    parameter int unsigned MAX_STARS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [11:0] memAddr,
    input  logic [2:0]  pixVal,
    output logic        starFound,
    output logic [5:0]  xOut,
    output logic [5:0]  yOut,
    input  logic        starDone,
    input  logic [5:0]  starLeft,
    input  logic [5:0]  starRight,
    input  logic [5:0]  starTop,
    input  logic [5:0]  starBottom,
    output logic [2:0]  starCount,
    output logic        scanDone
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FOUND, HOLD, RECORD, DONE} state_t;

    state_t     state, state_next;
    logic [5:0] x, y;
    logic [5:0] step_x, step_y, rec_x, rec_y;
    logic       step_end, rec_end;
    logic       bright, masked, hit, count_full;
    logic [5:0] right_q;

    assign memAddr    = 12'(y) * 12'(X_RES) + 12'(x);
    assign bright     = pixVal > THRESHOLD;
    assign hit        = bright && !masked;
    assign count_full = (starCount + 3'd1) == 3'(MAX_STARS);

    always_comb begin
        step_end = (x == X_RES - 6'd1) && (y == Y_RES - 6'd1);
        if (x == X_RES - 6'd1) begin
            step_x = '0;
            step_y = y + 6'd1;
        end else begin
            step_x = x + 6'd1;
            step_y = y;
        end
    end

`ifdef STAR_MASK_EN
    logic [5:0]           tbl_left   [MAX_STARS];
    logic [5:0]           tbl_right  [MAX_STARS];
    logic [5:0]           tbl_top    [MAX_STARS];
    logic [5:0]           tbl_bottom [MAX_STARS];
    logic [MAX_STARS-1:0] tbl_valid;
    logic [5:0]           left_q, top_q, bottom_q;

    always_comb begin
        masked = 1'b0;
        for (int unsigned i = 0; i < MAX_STARS; i++) begin
            if (tbl_valid[i] && x >= tbl_left[i] && x <= tbl_right[i] &&
                y >= tbl_top[i] && y <= tbl_bottom[i])
                masked = 1'b1;
        end
    end

    // The rest of a recorded star is skipped by the mask, so RECORD is a plain raster step.
    assign rec_x   = step_x;
    assign rec_y   = step_y;
    assign rec_end = step_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_valid <= '0;
            left_q    <= '0;
            top_q     <= '0;
            bottom_q  <= '0;
        end else begin
            if (state == HOLD && starDone) begin
                left_q   <= starLeft;
                top_q    <= starTop;
                bottom_q <= starBottom;
            end
            if ((state == IDLE || state == DONE) && start) begin
                tbl_valid <= '0;
            end else if (state == RECORD) begin
                for (int unsigned i = 0; i < MAX_STARS; i++)
                    if (3'(i) == starCount) tbl_valid[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == RECORD) begin
            for (int unsigned i = 0; i < MAX_STARS; i++) begin
                if (3'(i) == starCount) begin
                    tbl_left[i]   <= left_q;
                    tbl_right[i]  <= right_q;
                    tbl_top[i]    <= top_q;
                    tbl_bottom[i] <= bottom_q;
                end
            end
        end
    end
`else
    logic unused_extents;
    assign unused_extents = ^{starLeft, starTop, starBottom};
    assign masked = 1'b0;

    // Without a mask, resume just right of the star on the seed row.
    always_comb begin
        if (right_q >= X_RES - 6'd1) begin
            rec_x   = '0;
            rec_y   = y + 6'd1;
            rec_end = (y == Y_RES - 6'd1);
        end else begin
            rec_x   = right_q + 6'd1;
            rec_y   = y;
            rec_end = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        starFound  = 1'b0;
        scanDone   = 1'b0;
        case (state)
            IDLE:   if (start) state_next = ISSUE;
            ISSUE:  state_next = WAIT;
            WAIT:   state_next = CHECK;
            CHECK: begin
                if (hit)           state_next = FOUND;
                else if (step_end) state_next = DONE;
                else               state_next = ISSUE;
            end
            FOUND: begin
                starFound  = 1'b1;
                state_next = HOLD;
            end
            HOLD:   if (starDone) state_next = RECORD;
            RECORD: state_next = (count_full || rec_end) ? DONE : ISSUE;
            DONE: begin
                scanDone = 1'b1;
                if (start) state_next = ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            starCount <= '0;
            xOut      <= '0;
            yOut      <= '0;
            right_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x         <= '0;
                        y         <= '0;
                        starCount <= '0;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        xOut <= x;
                        yOut <= y;
                    end else if (!step_end) begin
                        x <= step_x;
                        y <= step_y;
                    end
                end
                HOLD: if (starDone) right_q <= starRight;
                RECORD: begin
                    starCount <= starCount + 3'd1;
                    if (!rec_end) begin
                        x <= rec_x;
                        y <= rec_y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_star_scanner.sv
// Bench for star_scanner: ROM and measurement-stage models, a raster-order reference model of the
// expected star seeds, and a per-cycle compare process. Follows STAR_MASK_EN like the design.
`timescale 1ns/1ps
module tb_star_scanner;
    localparam int XR   = 60;
    localparam int YR   = 60;
    localparam int MAXS = 4;

    logic        clk, reset, start, starFound, starDone, scanDone;
    logic [11:0] memAddr;
    logic [2:0]  pixVal, starCount;
    logic [5:0]  xOut, yOut, starLeft, starRight, starTop, starBottom;

    star_scanner #(
        .THRESHOLD(3'd0),
        .X_RES(6'd60),
        .Y_RES(6'd60),
        .MAX_STARS(MAXS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .memAddr(memAddr), .pixVal(pixVal),
        .starFound(starFound), .xOut(xOut), .yOut(yOut), .starDone(starDone),
        .starLeft(starLeft), .starRight(starRight), .starTop(starTop), .starBottom(starBottom),
        .starCount(starCount), .scanDone(scanDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {int x; int y;} xy_t;

    int  checks = 0;
    int  failures = 0;
    int  rl[8], rr[8], rt[8], rb[8];
    int  nrect = 0;
    xy_t exp_q[$];
    int  exp_n = 0;
    int  found_n = 0;
    int  first_x = -1;
    int  first_y = -1;
    bit  resp_en = 1'b1;
    bit  stray_req = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic add_rect(input int l, input int r, input int t, input int b);
        rl[nrect] = l; rr[nrect] = r; rt[nrect] = t; rb[nrect] = b;
        nrect++;
    endtask

    function automatic int rect_of(input int x, input int y);
        for (int i = 0; i < nrect; i++)
            if (x >= rl[i] && x <= rr[i] && y >= rt[i] && y <= rb[i]) return i;
        return -1;
    endfunction

    function automatic logic [2:0] rom(input int a);
        int x, y;
        x = a % XR;
        y = a / XR;
        if (rect_of(x, y) >= 0) return 3'((x + y) % 7 + 1);
        return 3'd0;
    endfunction

    // Expected seeds in raster order: stars are the bench rectangles, bright means inside one.
    task automatic build_model();
        int x, y, nx, cnt, r;
        bit fin, hit;
        int tl[$], tr[$], tt[$], tb[$];
        x = 0; y = 0; cnt = 0; fin = 1'b0;
        exp_q.delete();
        while (!fin) begin
            r = rect_of(x, y);
            hit = (r >= 0);
`ifdef STAR_MASK_EN
            foreach (tl[i])
                if (x >= tl[i] && x <= tr[i] && y >= tt[i] && y <= tb[i]) hit = 1'b0;
`endif
            nx = x + 1;
            if (hit) begin
                exp_q.push_back('{x: x, y: y});
                cnt++;
                tl.push_back(rl[r]); tr.push_back(rr[r]); tt.push_back(rt[r]); tb.push_back(rb[r]);
                if (cnt == MAXS) fin = 1'b1;
`ifndef STAR_MASK_EN
                nx = rr[r] + 1;
`endif
            end
            if (!fin) begin
                if (nx >= XR) begin
                    nx = 0;
                    if (y == YR - 1) fin = 1'b1;
                    else y++;
                end
                x = nx;
            end
        end
        exp_n = cnt;
    endtask

    // Image ROM with one cycle of read latency.
    initial begin
        int a;
        pixVal = 3'd0;
        forever begin
            @(negedge clk) a = int'(memAddr);
            @(posedge clk);
            #1 pixVal = rom(a);
        end
    end

    // Measurement stage: extents are only valid during the starDone cycle.
    initial begin
        int pend, rsel;
        pend = 0; rsel = 0;
        starDone = 1'b0;
        starLeft = 6'd0; starRight = 6'd63; starTop = 6'd0; starBottom = 6'd63;
        forever begin
            @(posedge clk);
            #2;
            if (starDone) begin
                starDone = 1'b0;
                starLeft = 6'd0; starRight = 6'd63; starTop = 6'd0; starBottom = 6'd63;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    starDone   = 1'b1;
                    starLeft   = 6'(rl[rsel]);
                    starRight  = 6'(rr[rsel]);
                    starTop    = 6'(rt[rsel]);
                    starBottom = 6'(rb[rsel]);
                end
            end else if (stray_req) begin
                stray_req = 1'b0;
                starDone = 1'b1;
                starLeft = 6'd0; starRight = 6'd59; starTop = 6'd0; starBottom = 6'd59;
            end
            if (starFound && resp_en && !reset) begin
                rsel = rect_of(int'(xOut), int'(yOut));
                if (rsel < 0) rsel = 0;
                pend = 3;
            end
        end
    end

    // Compare process: every seed against the model, and frozen outputs while waiting for starDone.
    bit          hold_active = 1'b0;
    logic [5:0]  hx, hy;
    logic [11:0] ha;
    always @(negedge clk) begin : compare
        xy_t e;
        if (reset) begin
            hold_active = 1'b0;
        end else if (starFound) begin
            found_n++;
            if (found_n == 1) begin
                first_x = int'(xOut);
                first_y = int'(yOut);
            end
            if (exp_q.size() == 0) begin
                check("extra_starFound", int'(starFound), 0);
            end else begin
                e = exp_q.pop_front();
                check("seed_x", int'(xOut), e.x);
                check("seed_y", int'(yOut), e.y);
            end
            check("scanDone_at_found", int'(scanDone), 0);
            hold_active = 1'b1;
            hx = xOut; hy = yOut; ha = memAddr;
        end else if (hold_active) begin
            check("hold_xOut", int'(xOut), int'(hx));
            check("hold_yOut", int'(yOut), int'(hy));
            check("hold_memAddr", int'(memAddr), int'(ha));
            if (starDone) hold_active = 1'b0;
        end
    end

    task automatic begin_scan();
        build_model();
        found_n = 0; first_x = -1; first_y = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_found(input int n);
        int c;
        c = 0;
        while (found_n < n && c < 12000) begin
            @(negedge clk);
            c++;
        end
        check("found_reached", found_n, n);
    endtask

    task automatic finish_scan(input string tag, input int lit_count, input int lit_fx, input int lit_fy);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!scanDone && c < 12000);
        check({tag, "_scanDone"}, int'(scanDone), 1);
        check({tag, "_starCount"}, int'(starCount), lit_count);
        check({tag, "_found_vs_model"}, found_n, exp_n);
        if (lit_count > 0) begin
            check({tag, "_first_x"}, first_x, lit_fx);
            check({tag, "_first_y"}, first_y, lit_fy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_starFound"}, int'(starFound), 0);
        check({tag, "_scanDone"}, int'(scanDone), 0);
        check({tag, "_starCount"}, int'(starCount), 0);
        check({tag, "_xOut"}, int'(xOut), 0);
        check({tag, "_yOut"}, int'(yOut), 0);
        check({tag, "_memAddr"}, int'(memAddr), 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_scanDone", int'(scanDone), 0);
        check("idle_memAddr", int'(memAddr), 0);

        // All-dark image, with an ignored mid-scan start and a stray starDone.
        nrect = 0;
        begin_scan();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) check("dark_scanDone_low", int'(scanDone), 0);
            if (cyc == 100) start = 1'b1;
            else if (cyc == 101) start = 1'b0;
            if (cyc == 200) stray_req = 1'b1;
        end while (!scanDone && cyc < 12000);
        check("dark_scanDone", int'(scanDone), 1);
        check_range("dark_latency", cyc + 1, 10799, 10803);
        check("dark_starCount", int'(starCount), 0);
        check("dark_found", found_n, 0);

        // Single star at (5,7); start asserted during HOLD together with starDone.
        nrect = 0;
        add_rect(5, 5, 7, 7);
        begin_scan();
        wait_found(1);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!starDone && cyc < 20);
        check("single_starDone_seen", int'(starDone), 1);
        @(negedge clk) start = 1'b0;
        finish_scan("single", 1, 5, 7);

        // 3x3 block.
        nrect = 0;
        add_rect(10, 12, 20, 22);
        begin_scan();
`ifdef STAR_MASK_EN
        finish_scan("block", 1, 10, 20);
`else
        finish_scan("block", 3, 10, 20);
`endif

        // Five separated stars, only four fit the table.
        nrect = 0;
        add_rect(2, 2, 1, 1);
        add_rect(30, 30, 3, 3);
        add_rect(50, 50, 10, 10);
        add_rect(7, 7, 40, 40);
        add_rect(20, 20, 50, 50);
        begin_scan();
        finish_scan("five", 4, 2, 1);
        check("five_found_pulses", found_n, 4);

        // Reset while waiting in HOLD, then rescan.
        nrect = 0;
        add_rect(5, 5, 7, 7);
        resp_en = 1'b0;
        begin_scan();
        wait_found(1);
        repeat (4) @(negedge clk);
        check("prereset_xOut", int'(xOut), 5);
        check("prereset_memAddr", int'(memAddr), 7 * 60 + 5);
        #2 reset = 1'b1;
        #1 check_reset_values("hold_reset");
        @(negedge clk);
        #2 reset = 1'b0;
        resp_en = 1'b1;
        repeat (5) @(negedge clk);
        check("postreset_scanDone", int'(scanDone), 0);
        check("postreset_memAddr", int'(memAddr), 0);
        begin_scan();
        finish_scan("rescan", 1, 5, 7);

        // Star on the very last pixel.
        nrect = 0;
        add_rect(59, 59, 59, 59);
        begin_scan();
        finish_scan("corner", 1, 59, 59);
        check("corner_memAddr", int'(memAddr), 3599);
        repeat (5) @(negedge clk);
        check("corner_memAddr_later", int'(memAddr), 3599);
        check("corner_scanDone_later", int'(scanDone), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
